// File: rtl/idann_pkg.sv
`default_nettype none
// ============================================================================
// Module   : idann_pkg
// Purpose  : Shared types and constants for the training-sample sequencer:
//            sequencer states, sample field widths and the packed sample.
// Revision : 1.0 - initial release
// ============================================================================
package idann_pkg;

  localparam int FEAT_W        = 4;
  localparam int TGT_W         = 4;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Byte layout on the write port is {target, x}.
  typedef struct packed {
    logic [TGT_W-1:0]  target;
    logic [FEAT_W-1:0] x;
  } sample_t;

endpackage
`default_nettype wire

// File: rtl/sample_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sample_buffer
// Purpose  : DEPTH-entry sample store. Appends at mem[count], reports
//            count/full/empty, and offers a registered read port by index.
// Revision : 1.0 - initial release
// ============================================================================
module sample_buffer
  import idann_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  sample_t                  wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output sample_t                  rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  sample_t    mem [DEPTH];
  logic       wr_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full && !clr;

  // Storage array; contents are meaningless once count drops to zero.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[count[IDX_W-1:0]] <= wr_data;
    end
  end

  // Fill level: flushed by clr, bumped by each accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (wr_ok) begin
      count <= count + CNT_W'(1);
    end
  end

  // Registered read port; holds its value until the next read or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sample_sequencer
// Purpose  : Buffers training samples and replays them for a programmed
//            number of epochs, handshaking each sample with the training
//            state machine (start pulse out, step-done in).
// Revision : 1.0 - initial release
// ============================================================================
module sample_sequencer
  import idann_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int EPOCH_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [7:0]             wr_data_i,
  input  logic                   clr_i,
  input  logic                   run_i,
  input  logic [EPOCH_W-1:0]     epochs_i,
  input  logic                   step_done_i,
  output logic [FEAT_W-1:0]      x_o,
  output logic [TGT_W-1:0]       target_o,
  output logic                   start_o,
  output logic                   busy_o,
  output logic                   train_done_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   ovf_o,
  output logic [EPOCH_W-1:0]     epoch_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  seq_state_t         state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [EPOCH_W-1:0] epoch, epoch_nxt, epoch_inc, epochs_lat;
  logic [CNT_W-1:0]   count;
  logic               full, empty, ovf;
  logic               load, run_ok, last_idx, buf_wr;
  sample_t            wr_sample, rd_sample;

  assign wr_sample = wr_data_i;
  assign run_ok    = run_i && (count != '0) && (epochs_i != '0);
  assign last_idx  = ({1'b0, idx} == (count - CNT_W'(1)));
  assign epoch_inc = (epoch == '1) ? epoch : epoch + EPOCH_W'(1);
  // The buffer is frozen outside IDLE so replay always sees the same data.
  assign buf_wr    = wr_en_i && (state == ST_IDLE) && !clr_i;

  sample_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .clr     (clr_i),
    .wr_en   (buf_wr),
    .wr_data (wr_sample),
    .rd_en   (load),
    .rd_idx  (idx_nxt),
    .rd_data (rd_sample),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // State, index, epoch and latched epoch-target registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      idx        <= '0;
      epoch      <= '0;
      epochs_lat <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      epoch <= epoch_nxt;
      if (!clr_i && run_ok && (state == ST_IDLE || state == ST_DONE)) begin
        epochs_lat <= epochs_i;
      end
    end
  end

  // Sticky overflow: any write the buffer could not take.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf <= 1'b0;
    end else if (clr_i) begin
      ovf <= 1'b0;
    end else if (wr_en_i && (state != ST_IDLE || full)) begin
      ovf <= 1'b1;
    end
  end

  // Next state plus index/epoch updates; load fetches the sample on START entry.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    epoch_nxt = epoch;
    load      = 1'b0;
    if (clr_i) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      epoch_nxt = '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (run_ok) begin
            state_nxt = ST_START;
            idx_nxt   = '0;
            epoch_nxt = '0;
            load      = 1'b1;
          end
        end
        ST_START: state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (step_done_i) begin
            if (!last_idx) begin
              idx_nxt   = idx + IDX_W'(1);
              state_nxt = ST_START;
              load      = 1'b1;
            end else begin
              idx_nxt   = '0;
              epoch_nxt = epoch_inc;
              if (epoch_inc == epochs_lat) begin
                state_nxt = ST_DONE;
              end else begin
                state_nxt = ST_START;
                load      = 1'b1;
              end
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from registered state.
  always_comb begin
    start_o      = (state == ST_START);
    busy_o       = (state == ST_START) || (state == ST_WAIT);
    train_done_o = (state == ST_DONE);
  end

  assign x_o      = rd_sample.x;
  assign target_o = rd_sample.target;
  assign count_o  = count;
  assign full_o   = full;
  assign empty_o  = empty;
  assign ovf_o    = ovf;
  assign epoch_o  = epoch;

endmodule
`default_nettype wire

// File: tb/tb_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_sequencer
// Purpose  : Self-checking bench for sample_sequencer; directed scenarios
//            plus randomized load/run sessions against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_sequencer;

  localparam int DEPTH   = 8;
  localparam int EPOCH_W = 8;

  logic               clk = 1'b0;
  logic               rst_i = 1'b0;
  logic               wr_en_i = 1'b0;
  logic [7:0]         wr_data_i = '0;
  logic               clr_i = 1'b0;
  logic               run_i = 1'b0;
  logic [EPOCH_W-1:0] epochs_i = '0;
  logic               step_done_i = 1'b0;
  logic [3:0]         x_o, target_o;
  logic               start_o, busy_o, train_done_o, full_o, empty_o, ovf_o;
  logic [3:0]         count_o;
  logic [EPOCH_W-1:0] epoch_o;

  sample_sequencer #(.DEPTH(DEPTH), .EPOCH_W(EPOCH_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .wr_en_i      (wr_en_i),
    .wr_data_i    (wr_data_i),
    .clr_i        (clr_i),
    .run_i        (run_i),
    .epochs_i     (epochs_i),
    .step_done_i  (step_done_i),
    .x_o          (x_o),
    .target_o     (target_o),
    .start_o      (start_o),
    .busy_o       (busy_o),
    .train_done_o (train_done_o),
    .count_o      (count_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .ovf_o        (ovf_o),
    .epoch_o      (epoch_o)
  );

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  bit [7:0]   model_q[$];
  bit         exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sample(input bit [7:0] d);
    wr_en_i = 1'b1;
    wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(d);
    else exp_ovf = 1'b1;
  endtask

  task automatic do_clr();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    model_q.delete();
    exp_ovf = 1'b0;
  endtask

  // Expected behaviour: every stored sample presented once per epoch, in
  // write order, for 'epochs' passes, then DONE holding the last sample.
  task automatic run_training(input int epochs, input int lat, input bit wr_in_wait,
                              input bit sd_in_start);
    int n;
    bit [7:0] s;
    n = model_q.size();
    run_i = 1'b1;
    epochs_i = EPOCH_W'(epochs);
    tick();
    run_i = 1'b0;
    for (int e = 0; e < epochs; e++) begin
      for (int i = 0; i < n; i++) begin
        s = model_q[i];
        check("start_pulse", start_o, 1);
        check("x_at_start", x_o, s[3:0]);
        check("target_at_start", target_o, s[7:4]);
        check("busy_in_start", busy_o, 1);
        check("epoch_progress", epoch_o, e);
        if (sd_in_start) step_done_i = 1'b1;
        tick();
        step_done_i = 1'b0;
        check("start_one_cycle", start_o, 0);
        check("x_held_in_wait", x_o, s[3:0]);
        for (int k = 1; k < lat; k++) begin
          tick();
          check("no_start_in_wait", start_o, 0);
        end
        if (wr_in_wait && i == 0) begin
          wr_en_i = 1'b1;
          wr_data_i = 8'($urandom);
          exp_ovf = 1'b1;
        end
        step_done_i = 1'b1;
        tick();
        step_done_i = 1'b0;
        wr_en_i = 1'b0;
      end
    end
    s = model_q[n-1];
    check("train_done", train_done_o, 1);
    check("busy_after_done", busy_o, 0);
    check("start_after_done", start_o, 0);
    check("epoch_final", epoch_o, epochs);
    check("x_last_sample", x_o, s[3:0]);
    check("ovf_after_run", ovf_o, exp_ovf);
    check("count_unchanged", count_o, n);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_x", x_o, 0);
    check("rst_target", target_o, 0);
    check("rst_start", start_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", train_done_o, 0);
    check("rst_count", count_o, 0);
    check("rst_full", full_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_ovf", ovf_o, 0);
    check("rst_epoch", epoch_o, 0);
    rst_i = 1'b1;
    tick();

    // Basic load and two-epoch replay
    write_sample(8'h21);
    write_sample(8'h43);
    write_sample(8'h65);
    check("load3_count", count_o, 3);
    check("load3_empty", empty_o, 0);
    check("load3_full", full_o, 0);
    run_training(2, 3, 1'b0, 1'b0);
    tick();
    check("done_sticky", train_done_o, 1);

    // Overflow when full, and writes dropped mid-training
    do_clr();
    for (int i = 0; i < DEPTH; i++) write_sample(8'($urandom));
    check("fill_full", full_o, 1);
    check("fill_ovf_clear", ovf_o, 0);
    write_sample(8'hEE);
    check("ovf_set", ovf_o, 1);
    check("ovf_count", count_o, DEPTH);
    run_training(2, 2, 1'b1, 1'b0);

    // run ignored with empty buffer or zero epochs; stray step_done
    do_clr();
    run_i = 1'b1;
    epochs_i = 8'd3;
    tick();
    run_i = 1'b0;
    check("run_empty_start", start_o, 0);
    check("run_empty_busy", busy_o, 0);
    tick();
    check("run_empty_start2", start_o, 0);
    write_sample(8'h5A);
    run_i = 1'b1;
    epochs_i = 8'd0;
    tick();
    run_i = 1'b0;
    check("run_zero_ep_start", start_o, 0);
    check("run_zero_ep_busy", busy_o, 0);
    step_done_i = 1'b1;
    tick();
    step_done_i = 1'b0;
    check("sd_idle_busy", busy_o, 0);
    check("sd_idle_done", train_done_o, 0);
    check("sd_idle_epoch", epoch_o, 0);
    write_sample(8'hC3);
    run_training(2, 1, 1'b0, 1'b1);

    // clr in WAIT with concurrent step_done and write
    do_clr();
    write_sample(8'h12);
    write_sample(8'h34);
    write_sample(8'h56);
    run_i = 1'b1;
    epochs_i = 8'd2;
    tick();
    run_i = 1'b0;
    wr_en_i = 1'b1;
    wr_data_i = 8'h99;
    tick();
    wr_en_i = 1'b0;
    check("wr_in_start_ovf", ovf_o, 1);
    clr_i = 1'b1;
    step_done_i = 1'b1;
    wr_en_i = 1'b1;
    tick();
    clr_i = 1'b0;
    step_done_i = 1'b0;
    wr_en_i = 1'b0;
    model_q.delete();
    exp_ovf = 1'b0;
    check("clr_busy", busy_o, 0);
    check("clr_start", start_o, 0);
    check("clr_count", count_o, 0);
    check("clr_empty", empty_o, 1);
    check("clr_x", x_o, 0);
    check("clr_target", target_o, 0);
    check("clr_ovf", ovf_o, 0);
    check("clr_epoch", epoch_o, 0);
    tick();
    check("clr_no_start", start_o, 0);

    // Asynchronous reset mid-epoch
    for (int i = 0; i < 4; i++) write_sample(8'($urandom));
    run_i = 1'b1;
    epochs_i = 8'd3;
    tick();
    run_i = 1'b0;
    repeat (2) tick();
    #2 rst_i = 1'b0;
    #1;
    model_q.delete();
    exp_ovf = 1'b0;
    check("arst_x", x_o, 0);
    check("arst_target", target_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_count", count_o, 0);
    check("arst_empty", empty_o, 1);
    check("arst_epoch", epoch_o, 0);
    #3 rst_i = 1'b1;
    tick();
    write_sample(8'hA7);
    write_sample(8'hB8);
    run_training(1, 2, 1'b0, 1'b0);

    // Randomized sessions
    for (int it = 0; it < 16; it++) begin
      int n;
      do_clr();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) write_sample(8'($urandom));
      if (n == DEPTH && $urandom_range(0, 1) == 1) write_sample(8'($urandom));
      check("rand_count", count_o, model_q.size());
      check("rand_full", full_o, model_q.size() == DEPTH);
      check("rand_ovf", ovf_o, exp_ovf);
      run_training($urandom_range(1, 3), $urandom_range(1, 4),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        run_training($urandom_range(1, 2), $urandom_range(1, 3), 1'b0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
